nibble_serial_adder: RTL

// - Multi-cycle WIDTH-bit adder built from one 4-bit ripple-carry slice reused over WIDTH/4 cycles.
// - Adds a + b + cin one nibble per clock, LSB nibble first, with the nibble carry registered between cycles.
// - Sits where a full-width combinational ripple chain is too long.
// - Valid/ready handshake on both sides; one operation in flight at a time.
//

---
 rtl/nibble_serial_adder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice reused over WIDTH/4 cycles, LSB nibble first.
// Optional macro NIBBLE_ADD_OVF_EN enables the registered signed-overflow flag; otherwise ovf is tied 0.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q, cout_q;
    logic             accept, last;

    logic [3:0]       nib_a, nib_b, nib_s;
    logic [4:0]       c;

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (idx == LAST_IDX);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Ripple slice over the nibble selected by idx; c[3] is the carry into the nibble's top bit.
    always_comb begin
        nib_a = a_q[{idx, 2'b00} +: 4];
        nib_b = b_q[{idx, 2'b00} +: 4];
        nib_s = '0;
        c     = '0;
        c[0]  = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_s[i] = nib_a[i] ^ nib_b[i] ^ c[i];
            c[i+1]   = (nib_a[i] & nib_b[i]) | (nib_b[i] & c[i]) | (c[i] & nib_a[i]);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: operand latches carry no reset; they are only read in RUN, which is entered by loading them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx     <= '0;
                        carry_q <= cin;
                    end
                end
                RUN: begin
                    sum_q[{idx, 2'b00} +: 4] <= nib_s;
                    carry_q                  <= c[4];
                    idx                      <= idx + 1'b1;
                    if (last) cout_q <= c[4];
                end
                default: ;
            endcase
        end
    end

`ifdef NIBBLE_ADD_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it, taken on the top nibble.
    always_ff @(posedge clk) begin
        if (rst)                         ovf_q <= 1'b0;
        else if ((state == RUN) && last) ovf_q <= c[3] ^ c[4];
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
